// File: rtl/prml_encoder_pkg.sv
// Shared PRML trellis definitions: encoder FSM states and the rate-1/2 code function,
// also used by the decoder's trellis tables.
package prml_encoder_pkg;

  typedef enum logic [1:0] {
    StPreamble,
    StRun,
    StTail
  } enc_state_t;

  // Trellis state {d[n-1], d[n-2]}
  typedef logic [1:0] trellis_t;

  localparam logic [7:0] TailLen = 8'd2;

  // Returns {c1, c0} for data bit d leaving state s
  function automatic logic [1:0] prml_encode(input logic d, input trellis_t s);
    logic c1;
    c1 = d ^ s[1];
    return {c1, c1 ^ s[0]};
  endfunction

endpackage

// File: rtl/prml_encoder_if.sv
// Data-side handshake and serial line of the PRML encoder.
interface prml_encoder_if;
  logic data_in;
  logic data_valid;
  logic data_ready;
  logic flush;
  logic out;
  logic phase;
  logic busy;

  modport master (
    output data_in, data_valid, flush,
    input  data_ready, out, phase, busy
  );

  modport slave (
    input  data_in, data_valid, flush,
    output data_ready, out, phase, busy
  );
endinterface

// File: rtl/prml_encoder.sv
// PRML transmit side: rate-1/2 trellis encoder with 2:1 serializer. One data bit per
// two-clock symbol period; c1 then c0 leave on the serial line.
module prml_encoder
  import prml_encoder_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 4
) (
  input  logic           i_clock,
  input  logic           i_reset,
  prml_encoder_if.slave  bus
);

  localparam logic [7:0] PreambleInit = 8'(PREAMBLE_LEN);

  enc_state_t r_state;
  logic       r_phase;
  logic [7:0] r_cnt;
  trellis_t   r_s;
  logic       r_c0;
  logic       r_out;
  logic       r_flush_pend;

  logic       w_ready;
  logic       w_d;
  logic [1:0] w_code;

  assign w_ready = (r_state == StRun) && r_phase && !r_flush_pend;
  // Without a handshake the symbol is zero-stuffed so the decoder's trellis stays in step
  assign w_d     = w_ready && bus.data_valid && bus.data_in;
  assign w_code  = prml_encode(w_d, r_s);

  assign bus.data_ready = w_ready;
  assign bus.busy       = (r_state != StRun);
  assign bus.out        = r_out;
  assign bus.phase      = r_phase;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StPreamble;
      r_phase      <= 1'b0;
      r_cnt        <= PreambleInit;
      r_s          <= 2'b00;
      r_c0         <= 1'b0;
      r_out        <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_phase <= ~r_phase;

      if (!r_phase) begin
        r_out <= r_c0;
      end else begin
        r_out <= w_code[1];
        r_c0  <= w_code[0];
        r_s   <= {w_d, r_s[1]};
      end

      unique case (r_state)
        StPreamble: begin
          if (r_phase) begin
            if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
            if (r_cnt <= 8'd1) r_state <= StRun;
          end
        end
        StRun: begin
          if (bus.flush) r_flush_pend <= 1'b1;
          if (r_phase && r_flush_pend) begin
            r_state      <= StTail;
            r_cnt        <= TailLen;
            r_flush_pend <= 1'b0;
          end
        end
        StTail: begin
          if (r_phase) begin
            if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
            if (r_cnt <= 8'd1) r_state <= StRun;
          end
        end
        default: r_state <= StPreamble;
      endcase
    end
  end

endmodule

// File: tb/tb_prml_encoder.sv
// Bench for prml_encoder: a scoreboard predicts every symbol at its selection cycle and
// compares c1/c0 on the serial line; directed checks cover preamble, flush, idle and reset.
module tb_prml_encoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  prml_encoder_if bus ();

  prml_encoder #(
    .PREAMBLE_LEN(4)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_encode(input logic d, input logic [1:0] s);
    logic c1;
    logic c0;
    c1 = d ^ s[1];
    c0 = d ^ s[1] ^ s[0];
    return {c1, c0};
  endfunction

  // Scoreboard: push the expected symbol on each selection cycle, pop it when c1 appears
  logic [1:0] sb_q[$];
  logic [1:0] cur;
  logic       have_cur;
  logic [1:0] m_s;
  logic       m_d;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      have_cur = 1'b0;
      m_s      = 2'b00;
      check_bit("rst_out", bus.out, 1'b0);
    end else if (!bus.phase) begin
      if (sb_q.size() > 0) begin
        cur      = sb_q.pop_front();
        have_cur = 1'b1;
      end else begin
        have_cur = 1'b0;
      end
      check_bit("c1", bus.out, have_cur ? cur[1] : 1'b0);
    end else begin
      check_bit("c0", bus.out, have_cur ? cur[0] : 1'b0);
      m_d = (bus.data_ready && bus.data_valid) ? bus.data_in : 1'b0;
      sb_q.push_back(ref_encode(m_d, m_s));
      m_s = {m_d, m_s[1]};
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bus.data_valid = 1'b1;
    bus.data_in    = b;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.data_ready && n < 20);
    check_bit("ready_wait", bus.data_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    bus.data_in    = 1'b0;
  endtask

  task automatic check_preamble();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_bit("pre_busy", bus.busy, 1'b1);
      check_bit("pre_ready", bus.data_ready, 1'b0);
      check_bit("pre_phase", bus.phase, i[0]);
    end
    @(negedge clk);
    check_bit("run_busy", bus.busy, 1'b0);
    check_bit("run_ready_ph0", bus.data_ready, 1'b0);
    @(negedge clk);
    check_bit("run_ready_ph1", bus.data_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.data_in    = 1'b0;
    bus.data_valid = 1'b0;
    bus.flush      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Preamble after reset
    check_preamble();

    // Back-to-back data from S=00
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);

    // Data then flush: tail returns trellis to 00
    send_bit(1'b1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check_bit("flush_pend_ready", bus.data_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_bit("tail_busy", bus.busy, 1'b1);
      check_bit("tail_ready", bus.data_ready, 1'b0);
    end
    @(negedge clk);
    check_bit("post_tail_busy", bus.busy, 1'b0);

    // Idle: zero-stuffing from S=00, data_ready keeps pulsing
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_bit("idle_out", bus.out, 1'b0);
      if (bus.phase) check_bit("idle_ready", bus.data_ready, 1'b1);
    end

    // Asynchronous reset while c1 is on the line
    @(posedge clk);
    #1;
    send_bit(1'b1);
    check_bit("pre_rst_c1", bus.out, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("rst_async_out", bus.out, 1'b0);
    check_bit("rst_async_phase", bus.phase, 1'b0);
    check_bit("rst_async_busy", bus.busy, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_preamble();

    // Random traffic with gaps and an occasional flush
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 39) == 0) begin
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
      end
      send_bit(1'($urandom_range(0, 1)));
    end
    repeat (10) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
